// File: rtl/vram_arb_pkg.sv
// Shared types and fixed latencies for the VRAM arbiter.
package vram_arb_pkg;

  localparam int VID_LAT = 3;
  localparam int CPU_LAT = 3;

  // One FSM state per CPU latency step plus the idle state.
  typedef enum logic [$clog2(CPU_LAT + 1)-1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } cpu_state_t;

endpackage

// File: rtl/vram_rd_pipe.sv
// Valid delay line of DEPTH stages; data is captured from tap_data one stage
// before the end, so out_data lines up with out_valid and holds until the next.
module vram_rd_pipe #(
  parameter int DEPTH  = 3,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] tap_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  logic [DEPTH-1:0] valid_sr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_sr <= '0;
      out_data <= '0;
    end else begin
      valid_sr <= {valid_sr[DEPTH-2:0], in_valid};
      if (valid_sr[DEPTH-2]) begin
        out_data <= tap_data;
      end
    end
  end

  assign out_valid = valid_sr[DEPTH-1];

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video fetches have absolute priority, the CPU gets
// idle slots. Define VRAM_BLANK_ONLY_EN to restrict CPU grants to blanking.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              display_on,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_valid,
  output logic [DATA_W-1:0] vid_data,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_we,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  cpu_state_t state;
  logic       permit;
  logic       grant;
  logic       is_write;

`ifdef VRAM_BLANK_ONLY_EN
  assign permit = ~display_on;
`else
  logic unused_display;
  assign unused_display = display_on;
  assign permit         = 1'b1;
`endif

  // A grant only happens in a cycle with no video request, so the CPU command
  // slot that follows can never collide with a video command.
  assign grant = (state == IDLE) && cpu_req && !vid_req && permit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      is_write  <= 1'b0;
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_wdata <= '0;
      cpu_ack   <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      ram_we  <= 1'b0;
      cpu_ack <= 1'b0;

      if (vid_req) begin
        ram_addr <= vid_addr;
      end else if (grant) begin
        ram_addr  <= cpu_addr;
        ram_we    <= cpu_we;
        ram_wdata <= cpu_wdata;
      end

      // The descriptor may change once cpu_req drops, so the access type is latched.
      case (state)
        IDLE: begin
          if (grant) begin
            state    <= ISSUE;
            is_write <= cpu_we;
          end
        end
        ISSUE: state <= READ;
        READ: begin
          state   <= DONE;
          cpu_ack <= 1'b1;
          if (!is_write) begin
            cpu_rdata <= ram_rdata;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  vram_rd_pipe #(
    .DEPTH (VID_LAT),
    .DATA_W(DATA_W)
  ) u_vid_pipe (
    .clk      (clk),
    .reset    (reset),
    .in_valid (vid_req),
    .tap_data (ram_rdata),
    .out_valid(vid_valid),
    .out_data (vid_data)
  );

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: synchronous RAM model plus a cycle-level reference
// model driven by the arbitration rules (priority, 4-cycle CPU slots, latency 3).
`timescale 1ns/1ps
module tb_vram_arbiter;
  localparam int ADDR_W = 11;
  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic display_on = 1'b0;
  logic vid_req = 1'b0;
  logic [ADDR_W-1:0] vid_addr = '0;
  logic vid_valid;
  logic [DATA_W-1:0] vid_data;
  logic cpu_req = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic cpu_we = 1'b0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  logic pre_we = 1'b0;
  logic [ADDR_W-1:0] pre_addr = '0;
  logic [DATA_W-1:0] pre_data = '0;
  logic [DATA_W-1:0] mem [0:2047];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int cpu_free = 0;
  logic [DATA_W-1:0] shadow [0:2047];
  bit vid_due [8];
  logic [DATA_W-1:0] vid_due_data [8];
  bit ack_due [8];
  bit ack_rd [8];
  logic [DATA_W-1:0] ack_data [8];
  bit exp_vid_valid = 1'b0;
  bit exp_ack = 1'b0;
  logic [DATA_W-1:0] exp_vid_data = '0;
  logic [DATA_W-1:0] exp_rdata = '0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .display_on(display_on),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_valid(vid_valid), .vid_data(vid_data),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      vid_due[i] = 1'b0;
      ack_due[i] = 1'b0;
    end
    exp_vid_valid = 1'b0;
    exp_ack = 1'b0;
    exp_vid_data = '0;
    exp_rdata = '0;
    cpu_free = cyc;
  endtask

  // Consume this cycle's inputs into the model, advance one clock, publish expectations.
  task automatic tick();
    int c;
    int s;
    bit perm;
    c = cyc;
    perm = 1'b1;
`ifdef VRAM_BLANK_ONLY_EN
    perm = !display_on;
`endif
    if (vid_req) begin
      s = (c + 3) % 8;
      vid_due[s] = 1'b1;
      vid_due_data[s] = shadow[vid_addr];
    end
    if (c >= cpu_free && cpu_req && !vid_req && perm) begin
      s = (c + 3) % 8;
      ack_due[s] = 1'b1;
      ack_rd[s] = !cpu_we;
      ack_data[s] = shadow[cpu_addr];
      if (cpu_we) shadow[cpu_addr] = cpu_wdata;
      cpu_free = c + 4;
    end
    @(posedge clk);
    #1;
    cyc++;
    s = cyc % 8;
    exp_vid_valid = vid_due[s];
    if (vid_due[s]) exp_vid_data = vid_due_data[s];
    vid_due[s] = 1'b0;
    exp_ack = ack_due[s];
    if (ack_due[s] && ack_rd[s]) exp_rdata = ack_data[s];
    ack_due[s] = 1'b0;
  endtask

  task automatic preload();
    for (int i = 0; i < 2048; i++) begin
      @(negedge clk);
      pre_we = 1'b1;
      pre_addr = ADDR_W'(i);
      pre_data = (i == 16) ? 8'hA5 : DATA_W'($urandom);
      shadow[i] = pre_data;
    end
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    tests++;
    if (ram_we !== 1'b0 || vid_valid !== 1'b0 || cpu_ack !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl: ram_we=%b vid_valid=%b cpu_ack=%b, required 0 0 0", ram_we, vid_valid, cpu_ack);
    end
    tests++;
    if (ram_addr !== '0 || ram_wdata !== '0) begin
      fails++;
      $display("FAIL reset_ram: ram_addr=%h ram_wdata=%h, required 0 0", ram_addr, ram_wdata);
    end
    tests++;
    if (vid_data !== '0 || cpu_rdata !== '0) begin
      fails++;
      $display("FAIL reset_data: vid_data=%h cpu_rdata=%h, required 0 0", vid_data, cpu_rdata);
    end
    reset = 1'b0;
    model_reset();
    tick();
  endtask

  task automatic test_single_video();
    vid_addr = 11'h010;
    vid_req = 1'b1;
    tick();
    vid_req = 1'b0;
    tests++;
    if (ram_addr !== 11'h010 || ram_we !== 1'b0) begin
      fails++;
      $display("FAIL vid_cmd: ram_addr=%h ram_we=%b, required 010 0", ram_addr, ram_we);
    end
    tick();
    tests++;
    if (vid_valid !== 1'b0) begin
      fails++;
      $display("FAIL vid_early: vid_valid=%b at +2, required 0", vid_valid);
    end
    tick();
    tests++;
    if (vid_valid !== 1'b1 || vid_data !== 8'hA5) begin
      fails++;
      $display("FAIL vid_single: vid_valid=%b vid_data=%h at +3, required 1 a5", vid_valid, vid_data);
    end
    tick();
    tests++;
    if (vid_valid !== 1'b0 || vid_data !== 8'hA5) begin
      fails++;
      $display("FAIL vid_hold: vid_valid=%b vid_data=%h at +4, required 0 a5", vid_valid, vid_data);
    end
  endtask

  task automatic test_cpu_write_read();
    cpu_addr = 11'h123;
    cpu_we = 1'b1;
    cpu_wdata = 8'h3C;
    cpu_req = 1'b1;
    tick();
    cpu_req = 1'b0;
    tests++;
    if (ram_addr !== 11'h123 || ram_we !== 1'b1 || ram_wdata !== 8'h3C) begin
      fails++;
      $display("FAIL cpu_wr_cmd: addr=%h we=%b wdata=%h, required 123 1 3c", ram_addr, ram_we, ram_wdata);
    end
    for (int k = 2; k <= 4; k++) begin
      tick();
      tests++;
      if (cpu_ack !== (k == 3)) begin
        fails++;
        $display("FAIL cpu_wr_ack: cpu_ack=%b at grant+%0d, required %b", cpu_ack, k, (k == 3));
      end
    end
    cpu_we = 1'b0;
    cpu_req = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 5) cpu_req = 1'b0;
      tests++;
      if (cpu_ack !== (k == 3 || k == 7)) begin
        fails++;
        $display("FAIL cpu_rd_ack: cpu_ack=%b at grant+%0d, required %b", cpu_ack, k, (k == 3 || k == 7));
      end
      if (k == 3 || k == 7) begin
        tests++;
        if (cpu_rdata !== 8'h3C) begin
          fails++;
          $display("FAIL cpu_rd_data: cpu_rdata=%h at grant+%0d, required 3c", cpu_rdata, k);
        end
      end
    end
  endtask

  task automatic test_priority();
    logic [DATA_W-1:0] want;
    want = shadow[11'h055];
    cpu_addr = 11'h055;
    cpu_we = 1'b0;
    cpu_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      vid_req = 1'b1;
      vid_addr = ADDR_W'(11'h200 + i);
      tick();
      tests++;
      if (cpu_ack !== 1'b0 || ram_we !== 1'b0 || ram_addr !== ADDR_W'(11'h200 + i)) begin
        fails++;
        $display("FAIL prio_starve: cpu_ack=%b ram_we=%b ram_addr=%h, required 0 0 %h", cpu_ack, ram_we, ram_addr, 11'h200 + i);
      end
    end
    vid_req = 1'b0;
    tick();
    tests++;
    if (ram_addr !== 11'h055 || ram_we !== 1'b0) begin
      fails++;
      $display("FAIL prio_issue: ram_addr=%h ram_we=%b at k+1, required 055 0", ram_addr, ram_we);
    end
    cpu_req = 1'b0;
    tick();
    tick();
    tests++;
    if (cpu_ack !== 1'b1 || cpu_rdata !== want) begin
      fails++;
      $display("FAIL prio_ack: cpu_ack=%b cpu_rdata=%h at k+3, required 1 %h", cpu_ack, cpu_rdata, want);
    end
    tick();
  endtask

  task automatic test_interleave();
    logic [DATA_W-1:0] want;
    want = shadow[11'h1F0];
    cpu_addr = 11'h1F0;
    cpu_we = 1'b0;
    cpu_req = 1'b1;
    tick();
    vid_req = 1'b1;
    vid_addr = 11'h123;
    tests++;
    if (ram_addr !== 11'h1F0 || ram_we !== 1'b0) begin
      fails++;
      $display("FAIL ilv_issue: ram_addr=%h ram_we=%b, required 1f0 0", ram_addr, ram_we);
    end
    tick();
    vid_req = 1'b0;
    cpu_req = 1'b0;
    tests++;
    if (ram_addr !== 11'h123 || ram_we !== 1'b0) begin
      fails++;
      $display("FAIL ilv_vid_cmd: ram_addr=%h ram_we=%b, required 123 0", ram_addr, ram_we);
    end
    tick();
    tests++;
    if (cpu_ack !== 1'b1 || cpu_rdata !== want) begin
      fails++;
      $display("FAIL ilv_ack: cpu_ack=%b cpu_rdata=%h, required 1 %h", cpu_ack, cpu_rdata, want);
    end
    tick();
    tests++;
    if (vid_valid !== 1'b1 || vid_data !== 8'h3C) begin
      fails++;
      $display("FAIL ilv_vid: vid_valid=%b vid_data=%h, required 1 3c", vid_valid, vid_data);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) begin
      vid_req = (i < 12);
      vid_addr = ADDR_W'(i * 37 + 5);
      tick();
      tests++;
      if (vid_valid !== exp_vid_valid || vid_data !== exp_vid_data) begin
        fails++;
        $display("FAIL b2b_vid: vid_valid=%b vid_data=%h, required %b %h", vid_valid, vid_data, exp_vid_valid, exp_vid_data);
      end
    end
  endtask

  task automatic test_display();
    display_on = 1'b1;
    cpu_addr = 11'h0AA;
    cpu_we = 1'b1;
    cpu_wdata = DATA_W'($urandom);
    cpu_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      tests++;
      if (cpu_ack !== exp_ack) begin
        fails++;
        $display("FAIL disp_hold: cpu_ack=%b, required %b", cpu_ack, exp_ack);
      end
    end
`ifdef VRAM_BLANK_ONLY_EN
    display_on = 1'b0;
    tick();
    display_on = 1'b1;
    cpu_req = 1'b0;
    tests++;
    if (ram_we !== 1'b1 || ram_addr !== 11'h0AA) begin
      fails++;
      $display("FAIL blank_grant: ram_we=%b ram_addr=%h, required 1 0aa", ram_we, ram_addr);
    end
    tick();
    tick();
    tests++;
    if (cpu_ack !== 1'b1) begin
      fails++;
      $display("FAIL blank_ack: cpu_ack=%b, required 1", cpu_ack);
    end
`else
    cpu_req = 1'b0;
`endif
    display_on = 1'b0;
    repeat (4) begin
      tick();
      tests++;
      if (cpu_ack !== exp_ack) begin
        fails++;
        $display("FAIL disp_drain: cpu_ack=%b, required %b", cpu_ack, exp_ack);
      end
    end
  endtask

  task automatic test_reset_in_read();
    cpu_addr = 11'h123;
    cpu_we = 1'b0;
    cpu_req = 1'b1;
    tick();
    cpu_req = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    tests++;
    if (cpu_ack !== 1'b0 || ram_we !== 1'b0 || ram_addr !== '0 || vid_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_async_ctrl: ack=%b we=%b addr=%h vv=%b, required 0 0 0 0", cpu_ack, ram_we, ram_addr, vid_valid);
    end
    tests++;
    if (vid_data !== '0 || cpu_rdata !== '0 || ram_wdata !== '0) begin
      fails++;
      $display("FAIL rst_async_data: vid_data=%h cpu_rdata=%h wdata=%h, required 0 0 0", vid_data, cpu_rdata, ram_wdata);
    end
    repeat (2) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++;
      if (cpu_ack !== 1'b0) begin
        fails++;
        $display("FAIL rst_no_ack: cpu_ack=%b after abort, required 0", cpu_ack);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      vid_req = ($urandom_range(0, 2) == 0);
      vid_addr = ADDR_W'($urandom_range(0, 31));
      display_on = 1'($urandom_range(0, 1));
      if (!cpu_req) begin
        if ($urandom_range(0, 3) == 0) begin
          cpu_req = 1'b1;
          cpu_we = 1'($urandom_range(0, 1));
          cpu_addr = ADDR_W'($urandom_range(0, 31));
          cpu_wdata = DATA_W'($urandom);
        end
      end else if ($urandom_range(0, 7) == 0) begin
        cpu_req = 1'b0;
      end
      tick();
      tests++;
      if (vid_valid !== exp_vid_valid || vid_data !== exp_vid_data) begin
        fails++;
        $display("FAIL rnd_vid: cyc=%0d vid_valid=%b vid_data=%h, required %b %h", cyc, vid_valid, vid_data, exp_vid_valid, exp_vid_data);
      end
      tests++;
      if (cpu_ack !== exp_ack || cpu_rdata !== exp_rdata) begin
        fails++;
        $display("FAIL rnd_cpu: cyc=%0d cpu_ack=%b cpu_rdata=%h, required %b %h", cyc, cpu_ack, cpu_rdata, exp_ack, exp_rdata);
      end
    end
    vid_req = 1'b0;
    cpu_req = 1'b0;
    display_on = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    preload();
    test_reset();
    test_single_video();
    test_cpu_write_read();
    test_priority();
    test_interleave();
    test_back_to_back();
    test_display();
    test_reset_in_read();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
